simd_addr_gen: RTL and testbench
================================

# simd_addr_gen

Parametrised operand-address generator for the SIMD datapath. Holds base addresses for the S, T and D operand streams, loaded from a shared address bus with any combination of load strobes. On start it walks a vector of LEN elements, issuing one {S,T,D} address triple per element over a valid/ready handshake and advancing each pointer by a programmable stride. It also accumulates sticky per-lane C/N/Z/V flags across the run and sits between the instruction decoder and the lane ALU array.

## Interface
- ADDR_W, 32, address width
- LANES, 4, SIMD lane count
- LANE_W, 8, lane data width in bits; default stride is LANES*LANE_W/8
- CNT_W, 16, element-count width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- s_ld, t_ld, d_ld  in  1 each  load the S/T/D base register from addrs; any combination is allowed
- len_ld  in  1  load the length register from addrs[CNT_W-1:0]
- stride_ld  in  1  load the stride register from addrs
- addrs  in  ADDR_W  shared load bus
- start  in  1  begin a vector run
- s_addr, t_addr, d_addr  out  ADDR_W  current working pointers
- out_valid  out  1  address triple valid
- out_ready  in  1  consumer accepts the triple
- last  out  1  current triple is the final element
- elem_idx  out  CNT_W  index of the current element
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- flag_we  in  1  capture lane flags
- flag_in  in  4*LANES  per-lane {V,Z,N,C}, lane 0 in the LSBs
- flags  out  4*LANES  sticky OR of captured flags

## Operation
- Base registers SB, TB, DB, LEN and STRIDE load on the clock edge whenever their strobe is high, in any state. Loading while busy only stages the values for the next run; it never affects the current run. Loads with no strobe hold their value.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start, LEN≠0: working pointers take SB/TB/DB, remaining takes LEN, elem_idx takes 0, flags clear, go to RUN.
  - IDLE, start, LEN=0: flags clear, go to DONE. No triple is issued.
  - RUN: out_valid=1. On out_valid&&out_ready, each pointer advances by STRIDE (modulo 2^ADDR_W, wraps silently), elem_idx increments, and remaining decrements.
  - RUN: the handshake with last=1 goes to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- If start and a base load occur in the same cycle, the run uses the pre-edge base values and the base registers take the new values.
- start is ignored in RUN and in DONE.
- last = (remaining==1) while in RUN.
- busy = 1 in RUN and DONE.
- Flags: on flag_we, flags <= flags | flag_in. This is accepted in every state.
  - If start is accepted in the same cycle, flags <= flag_in (the clear takes effect first).
  - flags persist after DONE until the next accepted start.
- Reset (asynchronous, valid at any point, including mid-run): state IDLE; SB/TB/DB/LEN 0; STRIDE = LANES*LANE_W/8; pointers 0; elem_idx 0; flags 0; out_valid, last, busy, done 0. A partially issued vector is abandoned.

## Timing
- Start to first out_valid: 1 cycle.
- Handshake-to-next triple: 0 bubbles; one element per cycle when out_ready is held high.
- Run duration with out_ready=1: LEN cycles in RUN + 1 DONE cycle.
- out_ready low stalls the run. Pointers, elem_idx and last hold, and out_valid stays high.
- All outputs are registered except out_valid, last and busy, which decode from state and remaining only.

## Structure
- Package simd_pkg holds:
  - the FSM state enum {IDLE, RUN, DONE}
  - flag bit indices C=0, N=1, Z=2, V=3 within each 4-bit lane group
  - a LANE_FLAGS=4 constant
- Sub-module simd_addr_ptr: an ADDR_W register with load (from a base) and add-stride-on-advance. It is instantiated three times (S, T, D).
- The FSM, counters and flag accumulator stay in simd_addr_gen.

## Test plan
- Load SB=0x100, TB=0x200, DB=0x300, LEN=3, stride default 4; start with out_ready=1. Required triples: (0x100,0x200,0x300), (0x104,0x204,0x304), (0x108,0x208,0x308). last is high on the third triple, then a 1-cycle done pulse, then busy low.
- Same setup, out_ready toggling 1,0,0,1,1. Triples hold during stalls, no element is skipped or repeated, and elem_idx goes 0,1,1,1,2.
- STRIDE=0x10, SB=0xFFFFFFF8, LEN=2. Second S address = 0x00000008 (wrap-around).
- LEN=0 then start. No out_valid; done pulses 1 cycle after start.
- Assert s_ld (addrs=0x500) mid-run. The current run is unaffected; the next run starts at S=0x500.
- Two flag_we writes, 0x0001 then 0x0100. flags=0x0101. A start with flag_we=1 and flag_in=0x0002 gives flags=0x0002. Reset asserted mid-run gives all outputs 0, and the next start runs cleanly.

Source files
------------

// File: rtl/simd_pkg.sv
// rtl/simd_pkg.sv - shared types and constants for the SIMD operand-address generator
package simd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit positions of each flag inside a lane's 4-bit {V,Z,N,C} group
    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 3;

    localparam int LANE_FLAGS = 4;

endpackage

// File: rtl/simd_addr_gen_if.sv
// rtl/simd_addr_gen_if.sv - address-triple stream between generator and lane ALU array
interface simd_addr_gen_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic [ADDR_W-1:0] s_addr;
    logic [ADDR_W-1:0] t_addr;
    logic [ADDR_W-1:0] d_addr;
    logic              out_valid;
    logic              out_ready;
    logic              last;
    logic [CNT_W-1:0]  elem_idx;

    modport master (
        output s_addr, t_addr, d_addr, out_valid, last, elem_idx,
        input  out_ready
    );

    modport slave (
        input  s_addr, t_addr, d_addr, out_valid, last, elem_idx,
        output out_ready
    );
endinterface

// File: rtl/simd_addr_ptr.sv
// rtl/simd_addr_ptr.sv - one working pointer: load from base, add stride on advance
module simd_addr_ptr #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    output logic [ADDR_W-1:0] ptr
);

    // Wraps modulo 2^ADDR_W by plain truncation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= base;
        end else if (advance) begin
            ptr <= ptr + stride;
        end
    end

endmodule

// File: rtl/simd_addr_gen.sv
// rtl/simd_addr_gen.sv - S/T/D operand-address generator with sticky lane flags
module simd_addr_gen
    import simd_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LANES  = 4,
    parameter int LANE_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        s_ld,
    input  logic                        t_ld,
    input  logic                        d_ld,
    input  logic                        len_ld,
    input  logic                        stride_ld,
    input  logic [ADDR_W-1:0]           addrs,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic                        flag_we,
    input  logic [LANE_FLAGS*LANES-1:0] flag_in,
    output logic [LANE_FLAGS*LANES-1:0] flags,
    simd_addr_gen_if.master             addr_if
);

    localparam logic [ADDR_W-1:0] DEF_STRIDE = ADDR_W'(LANES * LANE_W / 8);

    state_t            state;
    logic [ADDR_W-1:0] sb_q, tb_q, db_q, stride_q;
    logic [CNT_W-1:0]  len_q;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  elem_idx_q;
    logic              start_acc;
    logic              ptr_load;
    logic              fire;

    assign start_acc = (state == IDLE) && start;
    assign ptr_load  = start_acc && (len_q != '0);
    assign fire      = (state == RUN) && addr_if.out_ready;

    assign addr_if.out_valid = (state == RUN);
    assign addr_if.last      = (state == RUN) && (remaining == CNT_W'(1));
    assign addr_if.elem_idx  = elem_idx_q;
    assign busy              = (state != IDLE);

    // Staging registers: a run samples them only at start, so loads mid-run affect the next run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb_q     <= '0;
            tb_q     <= '0;
            db_q     <= '0;
            len_q    <= '0;
            stride_q <= DEF_STRIDE;
        end else begin
            if (s_ld)      sb_q     <= addrs;
            if (t_ld)      tb_q     <= addrs;
            if (d_ld)      db_q     <= addrs;
            if (len_ld)    len_q    <= addrs[CNT_W-1:0];
            if (stride_ld) stride_q <= addrs;
        end
    end

    simd_addr_ptr #(.ADDR_W(ADDR_W)) u_s_ptr (
        .clk(clk), .reset(reset), .load(ptr_load), .advance(fire),
        .base(sb_q), .stride(stride_q), .ptr(addr_if.s_addr)
    );

    simd_addr_ptr #(.ADDR_W(ADDR_W)) u_t_ptr (
        .clk(clk), .reset(reset), .load(ptr_load), .advance(fire),
        .base(tb_q), .stride(stride_q), .ptr(addr_if.t_addr)
    );

    simd_addr_ptr #(.ADDR_W(ADDR_W)) u_d_ptr (
        .clk(clk), .reset(reset), .load(ptr_load), .advance(fire),
        .base(db_q), .stride(stride_q), .ptr(addr_if.d_addr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            remaining  <= '0;
            elem_idx_q <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len_q != '0) begin
                            state      <= RUN;
                            remaining  <= len_q;
                            elem_idx_q <= '0;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (addr_if.out_ready) begin
                        remaining  <= remaining - CNT_W'(1);
                        elem_idx_q <= elem_idx_q + CNT_W'(1);
                        if (remaining == CNT_W'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // The start clear wins over the OR, so a same-cycle capture lands on a clean slate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= '0;
        end else if (start_acc) begin
            flags <= flag_we ? flag_in : '0;
        end else if (flag_we) begin
            flags <= flags | flag_in;
        end
    end

endmodule

// File: tb/tb_simd_addr_gen.sv
// tb/tb_simd_addr_gen.sv - self-checking bench for simd_addr_gen
module tb_simd_addr_gen;

    localparam int ADDR_W = 32;
    localparam int LANES  = 4;
    localparam int LANE_W = 8;
    localparam int CNT_W  = 16;
    localparam int FW     = 4 * LANES;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_ld, t_ld, d_ld, len_ld, stride_ld;
    logic [ADDR_W-1:0] addrs;
    logic              start;
    logic              busy, done;
    logic              flag_we;
    logic [FW-1:0]     flag_in;
    logic [FW-1:0]     flags;

    int n_checks = 0;
    int n_errs   = 0;

    logic [31:0] m_sb, m_tb, m_db, m_stride;
    int          m_len;
    logic [15:0] m_flags;

    always #5 clk = ~clk;

    simd_addr_gen_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    simd_addr_gen #(
        .ADDR_W(ADDR_W), .LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .s_ld(s_ld), .t_ld(t_ld), .d_ld(d_ld), .len_ld(len_ld), .stride_ld(stride_ld),
        .addrs(addrs), .start(start), .busy(busy), .done(done),
        .flag_we(flag_we), .flag_in(flag_in), .flags(flags),
        .addr_if(bus.master)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic load(input bit s, input bit t, input bit d, input bit l, input bit st,
                        input logic [31:0] v);
        s_ld = s; t_ld = t; d_ld = d; len_ld = l; stride_ld = st; addrs = v;
        tick();
        s_ld = 0; t_ld = 0; d_ld = 0; len_ld = 0; stride_ld = 0;
        if (s)  m_sb = v;
        if (t)  m_tb = v;
        if (d)  m_db = v;
        if (l)  m_len = int'(v[15:0]);
        if (st) m_stride = v;
    endtask

    task automatic setup(input logic [31:0] sb, input logic [31:0] tb, input logic [31:0] db,
                         input int len, input logic [31:0] str);
        load(1, 0, 0, 0, 0, sb);
        load(0, 1, 0, 0, 0, tb);
        load(0, 0, 1, 0, 0, db);
        load(0, 0, 0, 1, 0, 32'(len));
        load(0, 0, 0, 0, 1, str);
    endtask

    // mode 0: ready always high; 1: random ready/flags/stray starts; 2: ready pattern 1,0,0,1,1 then high
    task automatic run(input int mode, input bit mid_ld, input logic [31:0] mid_val);
        logic [31:0] sb, tb, db, str;
        logic [4:0]  pat;
        int          len, idx, cyc;
        bit          rdy, did_ld;
        pat = 5'b11001;
        sb = m_sb; tb = m_tb; db = m_db; str = m_stride; len = m_len;
        start = 1; tick(); start = 0;
        m_flags = '0;
        if (len == 0) begin
            chk("len0_done", done, 1);
            chk("len0_valid", bus.out_valid, 0);
            chk("len0_busy", busy, 1);
            tick();
            chk("len0_done_end", done, 0);
            chk("len0_busy_end", busy, 0);
            return;
        end
        idx = 0; cyc = 0; did_ld = 0;
        while (idx < len && cyc < 200) begin
            chk("valid", bus.out_valid, 1);
            chk("s_addr", bus.s_addr, 32'(sb + 32'(idx) * str));
            chk("t_addr", bus.t_addr, 32'(tb + 32'(idx) * str));
            chk("d_addr", bus.d_addr, 32'(db + 32'(idx) * str));
            chk("elem_idx", bus.elem_idx, idx);
            chk("last", bus.last, (idx == len - 1));
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
            case (mode)
                0:       rdy = 1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc < 5) ? pat[cyc] : 1'b1;
            endcase
            if (mode == 1) begin
                flag_we = 1'($urandom_range(0, 1));
                flag_in = 16'($urandom);
                start   = 1'($urandom_range(0, 1));
                if (flag_we) m_flags = m_flags | flag_in;
            end
            if (mid_ld && idx == 1 && !did_ld) begin
                s_ld = 1; addrs = mid_val; m_sb = mid_val; did_ld = 1;
            end
            bus.out_ready = rdy;
            tick();
            s_ld = 0; flag_we = 0; start = 0;
            if (rdy) idx++;
            cyc++;
        end
        bus.out_ready = 0;
        if (idx < len) chk("run_timeout", idx, len);
        chk("done_pulse", done, 1);
        chk("valid_done", bus.out_valid, 0);
        chk("last_done", bus.last, 0);
        chk("busy_done", busy, 1);
        chk("flags_done", flags, m_flags);
        tick();
        chk("done_clear", done, 0);
        chk("busy_clear", busy, 0);
        chk("flags_persist", flags, m_flags);
    endtask

    initial begin
        reset = 1; s_ld = 0; t_ld = 0; d_ld = 0; len_ld = 0; stride_ld = 0;
        addrs = '0; start = 0; flag_we = 0; flag_in = '0; bus.out_ready = 0;
        m_sb = 0; m_tb = 0; m_db = 0; m_len = 0; m_stride = 4; m_flags = 0;
        tick(); tick();
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", bus.s_addr, 0);
        chk("rst_idx", bus.elem_idx, 0);
        chk("rst_flags", flags, 0);
        reset = 0;
        tick();

        // Basic 3-element run, default stride
        load(1, 0, 0, 0, 0, 32'h100);
        load(0, 1, 0, 0, 0, 32'h200);
        load(0, 0, 1, 0, 0, 32'h300);
        load(0, 0, 0, 1, 0, 32'd3);
        run(0, 0, 0);

        // Stalls with ready pattern 1,0,0,1,1
        run(2, 0, 0);

        // Wrap-around: second S address lands at 0x8
        setup(32'hFFFF_FFF8, 32'h1000, 32'h2000, 2, 32'h10);
        run(0, 0, 0);
        chk("wrap_final_s", bus.s_addr, 32'h18);

        // Zero-length run
        load(0, 0, 0, 1, 0, 32'd0);
        run(0, 0, 0);

        // Mid-run base load only affects the next run
        setup(32'h100, 32'h200, 32'h300, 3, 32'd4);
        run(0, 1, 32'h500);
        run(0, 0, 0);

        // Combined strobes share the bus value
        load(1, 1, 1, 0, 0, 32'h4000);
        load(0, 0, 0, 1, 1, 32'd5);
        chk("combo_len_model", m_len, 5);
        run(0, 0, 0);

        // Flag accumulation, then start with a same-cycle capture
        flag_we = 1; flag_in = 16'h0001; tick();
        flag_in = 16'h0100; tick();
        flag_we = 0;
        chk("flags_or", flags, 16'h0101);
        load(0, 0, 0, 1, 0, 32'd0);
        flag_we = 1; flag_in = 16'h0002; start = 1; tick();
        flag_we = 0; start = 0;
        chk("flags_start", flags, 16'h0002);
        chk("flags_start_done", done, 1);
        tick();
        chk("flags_keep", flags, 16'h0002);

        // Randomised runs
        for (int i = 0; i < 8; i++) begin
            setup(32'($urandom), 32'($urandom), 32'($urandom),
                  $urandom_range(1, 7),
                  (i % 2 == 0) ? 32'($urandom_range(0, 64)) : 32'($urandom));
            run(1, 0, 0);
        end

        // Asynchronous reset mid-run
        setup(32'h700, 32'h800, 32'h900, 6, 32'h20);
        flag_we = 1; flag_in = 16'hA5A5; start = 1; tick();
        flag_we = 0; start = 0;
        bus.out_ready = 1; tick(); tick();
        #2 reset = 1;
        #1;
        chk("amid_valid", bus.out_valid, 0);
        chk("amid_last", bus.last, 0);
        chk("amid_busy", busy, 0);
        chk("amid_done", done, 0);
        chk("amid_s", bus.s_addr, 0);
        chk("amid_t", bus.t_addr, 0);
        chk("amid_d", bus.d_addr, 0);
        chk("amid_idx", bus.elem_idx, 0);
        chk("amid_flags", flags, 0);
        bus.out_ready = 0;
        tick();
        reset = 0;
        m_sb = 0; m_tb = 0; m_db = 0; m_len = 0; m_stride = 4; m_flags = 0;
        tick();

        // Clean run after reset; stride must be back at its default
        load(1, 0, 0, 0, 0, 32'h40);
        load(0, 0, 0, 1, 0, 32'd3);
        run(2, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
